// File: rtl/pipe_ctrl_hazard_pkg.sv
// Shared decode constants, ALU codes, forward-select and MULT sequencer encodings
// for the pipelined control path.
package pipe_ctrl_hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_MULT = 6'h18;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwdSel_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } mdState_t;

endpackage

// File: rtl/pipe_ctrl_hazard_md_seq.sv
// MULT sequencer: holds the MULT in EX for MD_LAT stall cycles (legal MD_LAT 1..15).
module md_seq
  import pipe_ctrl_hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mdopE,
  output logic md_busyE
);

  localparam logic [3:0] CNT_INIT = 4'(MD_LAT - 1);

  mdState_t   state, stateN;
  logic [3:0] cnt, cntN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateN;
      cnt   <= cntN;
    end
  end

  // The cnt==0 cycle is the exit cycle: EX releases the MULT at its closing edge.
  always_comb begin
    stateN   = state;
    cntN     = cnt;
    md_busyE = 1'b0;
    case (state)
      MD_IDLE: begin
        if (mdopE) begin
          stateN   = MD_BUSY;
          cntN     = CNT_INIT;
          md_busyE = 1'b1;
        end
      end
      MD_BUSY: begin
        if (cnt != '0) begin
          cntN     = cnt - 4'd1;
          md_busyE = 1'b1;
        end else begin
          stateN = MD_IDLE;
        end
      end
      default: stateN = MD_IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// 5-stage MIPS control path: ID decode, ID/EX-EX/MEM-MEM/WB control pipe, hazard unit
// and MULT sequencer. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl_hazard
  import pipe_ctrl_hazard_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int ALUC_W = 3,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opD,
  input  logic [5:0]        functD,
  input  logic [RA_W-1:0]   rsD,
  input  logic [RA_W-1:0]   rtD,
  input  logic [RA_W-1:0]   rsE,
  input  logic [RA_W-1:0]   rtE,
  input  logic [RA_W-1:0]   writeregE,
  input  logic [RA_W-1:0]   writeregM,
  input  logic [RA_W-1:0]   writeregW,
  input  logic              equalD,
  output logic              pcsrcD,
  output logic              jumpD,
  output logic              branchD,
  output logic [ALUC_W-1:0] alucontrolE,
  output logic              alusrcE,
  output logic              regdstE,
  output logic              mdopE,
  output logic              memwriteM,
  output logic              regwriteM,
  output logic              memtoregM,
  output logic              regwriteW,
  output logic              memtoregW,
  output logic              stallF,
  output logic              stallD,
  output logic              flushE,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              md_busyE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              regwriteD, memtoregD, memwriteD, alusrcD, regdstD, mdopD;
  logic [ALUC_W-1:0] alucontrolD;
  logic              regwriteE, memtoregE, memwriteE;
  logic              lwstall, brstall;

  always_comb begin
    regwriteD   = 1'b0;
    memtoregD   = 1'b0;
    memwriteD   = 1'b0;
    alusrcD     = 1'b0;
    regdstD     = 1'b0;
    mdopD       = 1'b0;
    branchD     = 1'b0;
    jumpD       = 1'b0;
    alucontrolD = '0;
    case (opD)
      OP_LW:   begin regwriteD = 1'b1; alusrcD = 1'b1; memtoregD = 1'b1; alucontrolD = ALUC_W'(ALU_ADD); end
      OP_SW:   begin memwriteD = 1'b1; alusrcD = 1'b1; alucontrolD = ALUC_W'(ALU_ADD); end
      OP_BEQ:  begin branchD = 1'b1; alucontrolD = ALUC_W'(ALU_SUB); end
      OP_ADDI: begin regwriteD = 1'b1; alusrcD = 1'b1; alucontrolD = ALUC_W'(ALU_ADD); end
      OP_J:    jumpD = 1'b1;
      OP_RTYPE: begin
        case (functD)
          FN_ADD:  begin regwriteD = 1'b1; regdstD = 1'b1; alucontrolD = ALUC_W'(ALU_ADD); end
          FN_SUB:  begin regwriteD = 1'b1; regdstD = 1'b1; alucontrolD = ALUC_W'(ALU_SUB); end
          FN_AND:  begin regwriteD = 1'b1; regdstD = 1'b1; alucontrolD = ALUC_W'(ALU_AND); end
          FN_OR:   begin regwriteD = 1'b1; regdstD = 1'b1; alucontrolD = ALUC_W'(ALU_OR);  end
          FN_SLT:  begin regwriteD = 1'b1; regdstD = 1'b1; alucontrolD = ALUC_W'(ALU_SLT); end
          FN_MULT: mdopD = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // ID/EX: flush and MULT hold never coincide, since flushE is masked by md_busyE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flushE) begin
      regwriteE   <= 1'b0;
      memtoregE   <= 1'b0;
      memwriteE   <= 1'b0;
      alusrcE     <= 1'b0;
      regdstE     <= 1'b0;
      mdopE       <= 1'b0;
      alucontrolE <= '0;
    end else if (!md_busyE) begin
      regwriteE   <= regwriteD;
      memtoregE   <= memtoregD;
      memwriteE   <= memwriteD;
      alusrcE     <= alusrcD;
      regdstE     <= regdstD;
      mdopE       <= mdopD;
      alucontrolE <= alucontrolD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || md_busyE) begin
      regwriteM <= 1'b0;
      memtoregM <= 1'b0;
      memwriteM <= 1'b0;
    end else begin
      regwriteM <= regwriteE;
      memtoregM <= memtoregE;
      memwriteM <= memwriteE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwriteW <= 1'b0;
      memtoregW <= 1'b0;
    end else begin
      regwriteW <= regwriteM;
      memtoregW <= memtoregM;
    end
  end

  md_seq #(.MD_LAT(MD_LAT)) uMdSeq (
    .clk      (clk),
    .rst      (rst),
    .mdopE    (mdopE),
    .md_busyE (md_busyE)
  );

  function automatic fwdSel_t fwdE(input logic [RA_W-1:0] src, input logic rwM,
                                   input logic [RA_W-1:0] wrM, input logic rwW,
                                   input logic [RA_W-1:0] wrW);
    if (src != '0 && rwM && src == wrM)      return FWD_MEM;
    else if (src != '0 && rwW && src == wrW) return FWD_WB;
    else                                     return FWD_NONE;
  endfunction

  assign lwstall = memtoregE & ((rtE == rsD) | (rtE == rtD));
  assign brstall = branchD & ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                              (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));

  assign stallF    = lwstall | brstall | md_busyE;
  assign stallD    = lwstall | brstall | md_busyE;
  assign flushE    = (lwstall | brstall) & ~md_busyE;
  assign pcsrcD    = branchD & equalD;
  assign forwardaD = (rsD != '0) & regwriteM & (rsD == writeregM);
  assign forwardbD = (rtD != '0) & regwriteM & (rtD == writeregM);
  assign forwardaE = fwdE(rsE, regwriteM, writeregM, regwriteW, writeregW);
  assign forwardbE = fwdE(rtE, regwriteM, writeregM, regwriteW, writeregW);

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallD) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flushE) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
